// File: rtl/extensor_de_signo_if.sv
// -----------------------------------------------------------------------------
// extensor_de_signo_if
// Bundles the decode-stage signals of the immediate generator.
//   morse  [31:0] : instruction word           (master -> slave)
//   selec  [2:0]  : immediate format selector  (master -> slave)
//   salida [31:0] : registered immediate       (slave  -> master)
// -----------------------------------------------------------------------------
interface extensor_de_signo_if;
    logic [31:0] morse;
    logic [2:0]  selec;
    logic [31:0] salida;

    // Decode logic side: supplies the instruction, consumes the immediate.
    modport master (
        output morse,
        output selec,
        input  salida
    );

    // Immediate generator side.
    modport slave (
        input  morse,
        input  selec,
        output salida
    );
endinterface

// File: rtl/extensor_de_signo.sv
// -----------------------------------------------------------------------------
// extensor_de_signo
// Registered RV32I immediate generator / sign extender.
//   clk   : core clock, rising edge
//   rst_n : synchronous reset, active low; clears the immediate register
//   bus   : slave side of extensor_de_signo_if (morse, selec in; salida out)
// The immediate for the selected format is computed combinationally and
// captured every cycle, so it appears one cycle after the instruction.
// -----------------------------------------------------------------------------
module extensor_de_signo (
    input  logic                  clk,
    input  logic                  rst_n,
    extensor_de_signo_if.slave    bus
);

    localparam logic [2:0] SEL_I     = 3'd0;
    localparam logic [2:0] SEL_SHAMT = 3'd1;
    localparam logic [2:0] SEL_S     = 3'd2;
    localparam logic [2:0] SEL_U     = 3'd3;
    localparam logic [2:0] SEL_B     = 3'd4;
    localparam logic [2:0] SEL_J     = 3'd5;
    localparam logic [2:0] SEL_J_ALT = 3'd6;

    logic        s;
    logic [31:0] salida_next;
    logic [31:0] salida_reg;

    assign s = bus.morse[31];

    always_comb begin
        salida_next = 32'h0000_0000;
        case (bus.selec)
            SEL_I:     salida_next = {{20{s}}, bus.morse[31:20]};
            // Shift amounts are unsigned: never sign-extend.
            SEL_SHAMT: salida_next = {27'b0, bus.morse[24:20]};
            SEL_S:     salida_next = {{20{s}}, bus.morse[31:25], bus.morse[11:7]};
            SEL_U:     salida_next = {bus.morse[31:12], 12'b0};
            SEL_B:     salida_next = {{19{s}}, bus.morse[31], bus.morse[7],
                                      bus.morse[30:25], bus.morse[11:8], 1'b0};
            SEL_J,
            SEL_J_ALT: salida_next = {{11{s}}, bus.morse[31], bus.morse[19:12],
                                      bus.morse[20], bus.morse[30:21], 1'b0};
            // Code 7 means "no immediate": drive a defined zero.
            default:   salida_next = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            salida_reg <= 32'h0000_0000;
        end else begin
            salida_reg <= salida_next;
        end
    end

    assign bus.salida = salida_reg;

endmodule

// File: tb/tb_extensor_de_signo.sv
// -----------------------------------------------------------------------------
// tb_extensor_de_signo
// Self-checking bench for extensor_de_signo: directed vectors with literal
// expectations, then randomized instructions/formats with occasional reset
// pulses, checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_extensor_de_signo;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    extensor_de_signo_if bus_if ();

    extensor_de_signo dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end else begin
            $display("ok   %s: salida=%08h", tag, got);
        end
    endtask

    // Reference model: immediates assembled from field values with shifts,
    // masks and arithmetic shifts of the signed word.
    function automatic logic [31:0] ref_imm(input logic [31:0] m, input int sel);
        logic signed [31:0] sm;
        logic [31:0]        sx;   // all ones when the word is negative
        sm = m;
        sx = 32'(sm >>> 31);
        case (sel)
            0: return 32'(sm >>> 20);
            1: return (m >> 20) & 32'h1F;
            2: return ((32'(sm >>> 25)) << 5) | ((m >> 7) & 32'h1F);
            3: return m & 32'hFFFF_F000;
            4: return (sx << 12)
                    | (((m >> 7)  & 32'h1)  << 11)
                    | (((m >> 25) & 32'h3F) << 5)
                    | (((m >> 8)  & 32'hF)  << 1);
            5, 6: return (sx << 20)
                    | (((m >> 12) & 32'hFF)  << 12)
                    | (((m >> 20) & 32'h1)   << 11)
                    | (((m >> 21) & 32'h3FF) << 1);
            default: return 32'h0;
        endcase
    endfunction

    // Present inputs, clock one edge, then compare just after the edge.
    task automatic step(input logic [31:0] m, input logic [2:0] sel,
                        input logic r, input logic [31:0] exp, input string tag);
        bus_if.morse = m;
        bus_if.selec = sel;
        rst_n        = r;
        @(posedge clk);
        #1;
        check_val(tag, bus_if.salida, exp);
    endtask

    logic [31:0] sweep_exp [8];
    logic [31:0] rm;
    logic [2:0]  rs;
    logic        rr;

    initial begin
        total = 0;
        bad   = 0;
        sweep_exp = '{32'h000007FD, 32'h0000001D, 32'h000007FC, 32'h7FDF0000,
                      32'h000007FC, 32'h000F0FFC, 32'h000F0FFC, 32'h00000000};

        // Reset with all-ones word.
        bus_if.morse = 32'hFFFF_FFFF;
        bus_if.selec = 3'd0;
        rst_n        = 1'b0;
        @(posedge clk);
        step(32'hFFFF_FFFF, 3'd0, 1'b0, 32'h0, "reset");
        rst_n = 1'b1;
        #1;
        check_val("hold_after_release", bus_if.salida, 32'h0);
        step(32'hFFFF_FFFF, 3'd0, 1'b1, 32'hFFFF_FFFF, "first_after_reset");

        // Positive-word sweep over every selector.
        for (int i = 0; i < 8; i++) begin
            step(32'h7FDF0E71, 3'(i), 1'b1, sweep_exp[i], $sformatf("sweep_sel%0d", i));
        end

        // Negative sign extension and selector corner cases.
        step(32'hFFF00093, 3'd0, 1'b1, 32'hFFFFFFFF, "neg_i");
        step(32'hFE112E23, 3'd2, 1'b1, 32'hFFFFFFFC, "neg_s");
        step(32'hFE000EE3, 3'd4, 1'b1, 32'hFFFFFFFC, "neg_b");
        step(32'hFFDFF06F, 3'd5, 1'b1, 32'hFFFFFFFC, "neg_j5");
        step(32'hFFDFF06F, 3'd6, 1'b1, 32'hFFFFFFFC, "neg_j6");
        step(32'hFFF00093, 3'd1, 1'b1, 32'h0000001F, "shamt_unsigned");
        step(32'hFFF00093, 3'd3, 1'b1, 32'hFFF00000, "neg_u");
        step(32'hFFF00093, 3'd7, 1'b1, 32'h00000000, "sel7_zero");

        // Constant inputs hold a constant output.
        step(32'hFFF00093, 3'd0, 1'b1, 32'hFFFFFFFF, "hold_a");
        step(32'hFFF00093, 3'd0, 1'b1, 32'hFFFFFFFF, "hold_b");

        // Randomized stream with a fixed mid-stream reset plus random ones.
        for (int i = 0; i < 300; i++) begin
            rm = $urandom;
            rs = 3'($urandom_range(0, 7));
            rr = (i == 40) ? 1'b0 : ($urandom_range(0, 19) != 0);
            step(rm, rs, rr, rr ? ref_imm(rm, int'(rs)) : 32'h0,
                 $sformatf("rand%0d_sel%0d_rst%0d_m%08h", i, rs, rr, rm));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
